sum_bcd_display: RTL and testbench
==================================

Name: sum_bcd_display

Overview:
- Downstream stage of the 4-bit ripple adder. It consumes the 5-bit result {cout, s[3:0]}, range 0..31.
- Converts the binary result to packed BCD with a sequential double-dabble engine.
- Drives active-low DE1 seven-segment digits.
- Uses a start/busy/done handshake, so a top level can register adder results and show them on HEX displays.

Parameters:
- IN_W, 5, binary input width (adder result width incl. carry).
- DIGITS, 2, number of BCD digits and 7-seg outputs. Must satisfy 10^DIGITS > 2^IN_W - 1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request conversion of bin. Sampled only in IDLE.
- bin  in  IN_W  binary value to convert. Sampled on the accepted start cycle.
- busy  out  1  high while a conversion is in progress (SHIFT and DONE states).
- done  out  1  one-cycle pulse when bcd/hex update.
- bcd  out  4*DIGITS  packed BCD result, digit 0 in [3:0].
- hex  out  7*DIGITS  active-low segments, digit k in [7k+6:7k], bit0 = seg a .. bit6 = seg g.

Behaviour:
- Reset (rst=1 at a clock edge, any state):
  - state = IDLE; busy = 0; done = 0; bcd = 0.
  - Every hex digit = 7'b1000000 ("0").
  - Internal shift/count registers cleared.
  - Reset mid-conversion aborts the conversion; no done pulse is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - On start=1, load the shift register with {4*DIGITS zeros, bin}, set count = 0 and go to SHIFT.
  - busy rises on the following cycle.
- SHIFT: one iteration per cycle.
  - Add 3 to each BCD nibble >= 5, then shift the whole register left by 1.
  - count increments. After IN_W iterations go to DONE.
- DONE:
  - bcd <= upper BCD field of the shift register.
  - hex <= decoded bcd.
  - done = 1 for exactly this cycle, then return to IDLE.
- Latency: start sampled at edge N; done = 1 and outputs valid in the cycle following edge N+IN_W+1. With defaults, 6 cycles after the accept edge.
- start while busy (SHIFT or DONE) is ignored. It is not queued, and bin changes are ignored.
- Back-to-back operation: start asserted in the cycle after DONE (IDLE again) is accepted. Throughput is one conversion per IN_W+2 cycles.
- bcd/hex hold their last value between conversions. They change only in DONE or on reset.
- Nibble codes > 9 cannot occur for legal parameters. The decoder still maps them to blank (7'h7F).
- Segment codes, 0..9:
  - 1000000, 1111001, 0100100, 0110000, 0011001
  - 0010010, 0000010, 1111000, 0000000, 0010000

Optional Feature:
- Macro: SUM_BCD_LEADING_ZERO_BLANK_EN.
- Defined: in DONE, every digit above digit 0 that is zero and has only zero digits above it is blanked (7'h7F). Digit 0 always displays. The bcd output is unaffected. Reset still shows "0" on digit 0 only, with upper digits blank.
- Undefined: all digits always display, including leading zeros.

Decomposition:
- Package sum_bcd_pkg holds:
  - state enum (IDLE, SHIFT, DONE);
  - SEG_BLANK = 7'h7F;
  - the ten segment-pattern constants;
  - a function computing the count width from IN_W.
- Sub-module seg7_decode: 4-bit BCD in, 7-bit active-low segments out. It is purely combinational and instantiated DIGITS times.

Test Plan:
- Reset: hold rst 3 cycles. Expect busy=0, done=0, bcd=8'h00, hex={7'b1000000, 7'b1000000}. With the macro defined, expect hex[13:7]=7'h7F.
- Max sum: bin=5'd31 (15+15+cin=1), start for 1 cycle. Expect done 6 cycles after accept, bcd=8'h31, hex[13:7]=0110000, hex[6:0]=1111001.
- Zero and single-digit values:
  - bin=0 gives bcd=8'h00.
  - bin=9 gives bcd=8'h09 and hex[6:0]=0010000.
  - bin=10 gives bcd=8'h10.
- Start while busy: accept bin=17. Two cycles later pulse start with bin=3. Expect exactly one done, bcd=8'h17, then busy=0.
- Reset mid-conversion: accept bin=25 and assert rst in the 3rd SHIFT cycle. Expect no done, bcd stays 8'h00, and the next start with bin=12 yields 8'h12.
- Exhaustive: all a,b in 0..15 and cin in 0..1 fed through a golden 4-bit adder into bin, issuing a start each time busy=0. Compare bcd to a decimal reference and hex to the segment table.

Source files
------------

// File: rtl/sum_bcd_pkg.sv
// Shared types and constants for the sum_bcd_display block: FSM state
// encoding, active-low seven-segment patterns and a count-width helper.
package sum_bcd_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Active-low segments, bit0 = seg a .. bit6 = seg g
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Bits needed to hold an iteration index 0..in_w
  function automatic int unsigned cnt_width(int unsigned in_w);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) <= in_w) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment decoder.
// Codes above 9 map to a blank digit.
module seg7_decode
  import sum_bcd_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  // Table lookup; out-of-range nibbles blank the digit
  always_comb begin
    seg_o = SEG_BLANK;
    case (bcd_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sum_bcd_display.sv
// Binary-to-BCD converter (sequential double dabble) driving active-low
// seven-segment digits, with a start/busy/done handshake.
// Optional build macro SUM_BCD_LEADING_ZERO_BLANK_EN blanks leading zero
// digits above digit 0 on the hex outputs (bcd is unaffected).
module sum_bcd_display
  import sum_bcd_pkg::*;
#(
  parameter int unsigned IN_W   = 5,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned SrW  = BcdW + IN_W;
  localparam int unsigned CntW = cnt_width(IN_W);

  state_e              state_q;
  logic [SrW-1:0]      sr_q;
  logic [CntW-1:0]     cnt_q;
  logic [BcdW-1:0]     bcd_q;
  logic [7*DIGITS-1:0] hex_q;
  logic                done_q;

  logic [SrW-1:0]      sr_adj;
  logic [BcdW-1:0]     bcd_field;
  logic [7*DIGITS-1:0] seg_dec;
  logic [7*DIGITS-1:0] hex_d;
  logic [7*DIGITS-1:0] hex_rst;
`ifdef SUM_BCD_LEADING_ZERO_BLANK_EN
  logic                lead_zero;
`endif

  assign bcd_field = sr_q[IN_W +: BcdW];

  // Add-3 correction on every BCD nibble that is 5 or more
  always_comb begin
    sr_adj = sr_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (sr_q[IN_W + 4*k +: 4] >= 4'd5) begin
        sr_adj[IN_W + 4*k +: 4] = sr_q[IN_W + 4*k +: 4] + 4'd3;
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    seg7_decode u_seg7_decode (
      .bcd_i (bcd_field[4*g +: 4]),
      .seg_o (seg_dec[7*g +: 7])
    );
  end

  // Display pattern loaded in DONE, optionally with leading zeros blanked
  always_comb begin
    hex_d = seg_dec;
`ifdef SUM_BCD_LEADING_ZERO_BLANK_EN
    lead_zero = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      if (lead_zero && (bcd_field[4*k +: 4] == 4'd0)) begin
        hex_d[7*k +: 7] = SEG_BLANK;
      end else begin
        lead_zero = 1'b0;
      end
    end
`endif
  end

  // Display pattern after reset: "0" on digit 0, upper digits per build option
  always_comb begin
    hex_rst = '0;
    for (int k = 0; k < DIGITS; k++) begin
`ifdef SUM_BCD_LEADING_ZERO_BLANK_EN
      hex_rst[7*k +: 7] = (k == 0) ? SEG_0 : SEG_BLANK;
`else
      hex_rst[7*k +: 7] = SEG_0;
`endif
    end
  end

  // Control FSM with registered outputs; reset aborts any conversion
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      hex_q   <= hex_rst;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            sr_q    <= {{BcdW{1'b0}}, bin};
            cnt_q   <= '0;
            state_q <= StShift;
          end
        end
        StShift: begin
          sr_q  <= sr_adj << 1;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(IN_W - 1)) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          bcd_q   <= bcd_field;
          hex_q   <= hex_d;
          done_q  <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign bcd  = bcd_q;
  assign hex  = hex_q;

endmodule

// File: tb/tb_sum_bcd_display.sv
// Directed bench for sum_bcd_display with a scoreboard of expected results
// pushed at each accepted start and popped on each done pulse.
module tb_sum_bcd_display;

  localparam int unsigned IN_W   = 5;
  localparam int unsigned DIGITS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  bin;
  logic        busy;
  logic        done;
  logic [7:0]  bcd;
  logic [13:0] hex;

  always #5 clk = ~clk;

  sum_bcd_display #(
    .IN_W   (IN_W),
    .DIGITS (DIGITS)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .hex   (hex)
  );

  typedef struct packed {
    logic [7:0]  bcd;
    logic [13:0] hex;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  logic [13:0] hex_reset;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int v);
    exp_t e;
    int   tens;
    int   ones;
    tens  = v / 10;
    ones  = v % 10;
    e.bcd = {4'(tens), 4'(ones)};
    e.hex = {seg_tab[tens], seg_tab[ones]};
`ifdef SUM_BCD_LEADING_ZERO_BLANK_EN
    if (tens == 0) e.hex[13:7] = 7'h7F;
`endif
    return e;
  endfunction

  // Scoreboard: every done pulse must match the oldest accepted request
  always @(negedge clk) begin
    if (!rst && done) begin
      exp_t e;
      done_cnt++;
      check("done_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sb_bcd", 32'(bcd), 32'(e.bcd));
        check("sb_hex", 32'(hex), 32'(e.hex));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("idle_timeout", 32'(n), 32'd0);
  endtask

  // Drive start for one cycle when idle; optionally record the expectation
  task automatic issue(input int v, input bit push);
    wait_idle();
    start = 1'b1;
    bin   = 5'(v);
    if (push) sb.push_back(model(v));
    @(negedge clk);
    start = 1'b0;
    bin   = 5'($urandom_range(0, 31));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int lat;
    int d0;
`ifdef SUM_BCD_LEADING_ZERO_BLANK_EN
    hex_reset = {7'h7F, 7'b1000000};
`else
    hex_reset = {7'b1000000, 7'b1000000};
`endif
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd",  32'(bcd),  32'h00);
    check("rst_hex",  32'(hex),  32'(hex_reset));
    rst = 1'b0;
    @(negedge clk);

    // Max sum with latency measurement (negedge index after accept edge)
    issue(31, 1'b1);
    lat = 1;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd7);
    check("max_hex_hi", 32'(hex[13:7]), 32'(7'b0110000));
    check("max_hex_lo", 32'(hex[6:0]),  32'(7'b1111001));
    drain();

    // Zero and single-digit values
    issue(0, 1'b1);
    drain();
    issue(9, 1'b1);
    drain();
    check("nine_hex_lo", 32'(hex[6:0]), 32'(7'b0010000));
    issue(10, 1'b1);
    drain();

    // Start while busy must be ignored
    d0 = done_cnt;
    issue(17, 1'b1);
    @(negedge clk);
    start = 1'b1;
    bin   = 5'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("busy_ignore_dones", 32'(done_cnt - d0), 32'd1);
    check("busy_ignore_bcd", 32'(bcd), 32'h17);
    check("busy_ignore_idle", 32'(busy), 32'd0);

    // Reset during the third SHIFT cycle aborts the conversion
    d0 = done_cnt;
    issue(25, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_bcd", 32'(bcd), 32'h00);
    check("abort_hex", 32'(hex), 32'(hex_reset));
    check("abort_busy", 32'(busy), 32'd0);
    issue(12, 1'b1);
    drain();
    check("after_abort_bcd", 32'(bcd), 32'h12);

    // Exhaustive adder results, issued back-to-back whenever idle
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          issue(a + b + c, 1'b1);
        end
      end
    end
    drain();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
